// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl
//   Line-granular backing memory that sits behind the I/D memory arbiter.
//   One request is serviced at a time. The request is latched when it is
//   accepted, the line is read or written after a fixed LATENCY, and a single
//   mem_rvalid pulse ends the transaction (for both reads and writes).
//
//   Optional feature: define MEM_BOUNDS_CHECK_EN to add the mem_err port.
//   Out-of-range or misaligned requests then suppress the write, return zero
//   data and raise mem_err together with mem_rvalid. Without the macro, the
//   byte-offset bits and all address bits above the line index are ignored,
//   so the index wraps modulo DEPTH_LINES.
//
// Ports
//   clk         in   1           clock, rising edge
//   rst         in   1           asynchronous, active-high reset
//   mem_req     in   1           request, held by the arbiter until mem_rvalid
//   mem_we      in   1           1 = write line, 0 = read line
//   mem_addr    in   ADDR_WIDTH  byte address
//   mem_wdata   in   DATA_WIDTH  write line data
//   mem_rdata   out  DATA_WIDTH  registered response data (write data is echoed)
//   mem_rvalid  out  1           one-cycle completion pulse
//   mem_err     out  1           bounds/alignment error (MEM_BOUNDS_CHECK_EN only)

module main_memory_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rvalid
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic                  mem_err
`endif
);

    localparam int OFS_W = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    // The counter only ever holds values up to LATENCY-1.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;

    logic [DATA_WIDTH-1:0] mem_array [DEPTH_LINES];

    logic                  lat_we;
    logic [IDX_W-1:0]      lat_idx;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_err;

    logic                  accept;
    logic                  do_op;
    logic                  op_from_live;
    logic                  op_we;
    logic [IDX_W-1:0]      op_idx;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic                  op_err;
    logic [IDX_W-1:0]      live_idx;
    logic                  live_err;

    assign live_idx = mem_addr[OFS_W +: IDX_W];

`ifdef MEM_BOUNDS_CHECK_EN
    // A request is bad if any byte-offset bit is set or any bit above the
    // index field is set (i.e. address >= DEPTH_LINES * line bytes).
    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] ofs_mask;
        ofs_mask = ADDR_WIDTH'((64'd1 << OFS_W) - 64'd1);
        return ((a & ofs_mask) != '0) || ((a >> (OFS_W + IDX_W)) != '0);
    endfunction

    assign live_err = addr_bad(mem_addr);
`else
    // Offset and upper address bits are intentionally don't-care here.
    logic addr_unused;
    assign addr_unused = ^mem_addr;
    assign live_err    = 1'b0;
`endif

    assign accept = (state == IDLE) && mem_req;

    // Next-state logic. With LATENCY==1 the array op happens on the
    // acceptance edge itself, so it must use the live request inputs.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        do_op        = 1'b0;
        op_from_live = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    cnt_nxt = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_nxt    = RESP;
                        do_op        = 1'b1;
                        op_from_live = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    do_op     = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // mem_req is ignored here even if still high.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign op_we    = op_from_live ? mem_we    : lat_we;
    assign op_idx   = op_from_live ? live_idx  : lat_idx;
    assign op_wdata = op_from_live ? mem_wdata : lat_wdata;
    assign op_err   = op_from_live ? live_err  : lat_err;

    // Request capture: later changes on the inputs during BUSY are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= mem_we;
            lat_idx   <= live_idx;
            lat_wdata <= mem_wdata;
            lat_err   <= live_err;
        end
    end

    // Storage array, no reset so it maps onto block/distributed RAM.
    // A reset mid-flight returns the FSM to IDLE, so do_op never fires and
    // the pending write is dropped.
    always_ff @(posedge clk) begin
        if (do_op && op_we && !op_err) begin
            mem_array[op_idx] <= op_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mem_rvalid <= do_op;
            if (do_op) begin
                if (op_err) begin
                    mem_rdata <= '0;
                end else if (op_we) begin
                    mem_rdata <= op_wdata;
                end else begin
                    mem_rdata <= mem_array[op_idx];
                end
            end
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= do_op && op_err;
        end
    end
`endif

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Testbench for main_memory_ctrl (default build, no bounds checking).
// Two instances share clock and reset: one with LATENCY=5, one with LATENCY=1.
// A driver issues transactions and pushes the expected response (data and the
// cycle in which mem_rvalid must be seen) into a per-instance queue; a monitor
// pops and compares whenever mem_rvalid is high. The reference model is a
// plain array of lines indexed by (addr / 16) % 1024.

module tb_main_memory_ctrl;

    localparam int DW    = 128;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req5, we5, rvalid5;
    logic [AW-1:0] addr5;
    logic [DW-1:0] wdata5, rdata5;
    logic          req1, we1, rvalid1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1, rdata1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t          q5[$];
    exp_t          q1[$];
    logic [DW-1:0] ref5 [DEPTH];
    logic [DW-1:0] ref1 [DEPTH];

    main_memory_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LINES(DEPTH), .LATENCY(5)
    ) dut5 (
        .clk(clk), .rst(rst), .mem_req(req5), .mem_we(we5), .mem_addr(addr5),
        .mem_wdata(wdata5), .mem_rdata(rdata5), .mem_rvalid(rvalid5)
    );

    main_memory_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LINES(DEPTH), .LATENCY(1)
    ) dut1 (
        .clk(clk), .rst(rst), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
        .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_rvalid(rvalid1)
    );

    always #5 clk = ~clk;

    // cyc counts rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [DW-1:0] act,
                                  input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid5 === 1'b1) begin
            if (q5.size() == 0) begin
                check("rvalid5_unexpected", 1, 0);
            end else begin
                e = q5.pop_front();
                check("lat5_cycle", DW'(cyc), DW'(e.due));
                check("rdata5", rdata5, e.data);
            end
        end
        if (rvalid1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("rvalid1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                check("lat1_cycle", DW'(cyc), DW'(e.due));
                check("rdata1", rdata1, e.data);
            end
        end
    end

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (sel == 0) begin
            req5 = r; we5 = w; addr5 = a; wdata5 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one transaction. Called #1 after a rising edge; returns #1 after
    // the edge on which the DUT is back in IDLE, so a call that follows
    // immediately is accepted on the earliest legal edge (T+LATENCY+1).
    // With hold=1, mem_req stays high through the response cycle with
    // scrambled inputs, which the DUT must ignore.
    task automatic txn(input int sel, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic hold);
        int   lat;
        int   t;
        int   idx;
        exp_t e;
        lat = (sel == 0) ? 5 : 1;
        drive(sel, 1'b1, w, a, d);
        @(posedge clk);
        #1;
        t   = cyc;
        idx = int'((a / 32'd16) % 32'(DEPTH));
        if (sel == 0) begin
            if (w) ref5[idx] = d;
            e.data = ref5[idx];
        end else begin
            if (w) ref1[idx] = d;
            e.data = ref1[idx];
        end
        // rvalid is visible in the cycle that ends with edge T+LATENCY.
        e.due = t + lat - 1;
        if (sel == 0) q5.push_back(e);
        else          q1.push_back(e);
        drive(sel, hold, 1'($urandom_range(0, 1)), $urandom, rand_line());
        repeat (lat) @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int line;
        int alias_n;
        int ofs;
        line    = $urandom_range(0, 15);
        alias_n = $urandom_range(0, 3);
        ofs     = $urandom_range(0, 15);
        return AW'((line + alias_n * DEPTH) * 16 + ofs);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d expected completion earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] old80;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Reset for three cycles; outputs must be cleared.
        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid5", DW'(rvalid5), 0);
        check("rst_rdata5", rdata5, 0);
        check("rst_rvalid1", DW'(rvalid1), 0);
        check("rst_rdata1", rdata1, 0);
        rst = 1'b0;

        // Write then (after a mid-cycle reset) read back line 0x40.
        txn(0, 1'b1, 32'h40, 128'hDEADBEEF_0123, 1'b0);
        idle(1);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_rdata5", rdata5, 0);
        check("midrst_rvalid5", DW'(rvalid5), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        txn(0, 1'b0, 32'h40, '0, 1'b0);

        // Request held through the response cycle, then back-to-back.
        txn(0, 1'b1, 32'h50, 128'h5555_AAAA_0000_1111, 1'b1);
        txn(0, 1'b0, 32'h50, '0, 1'b1);
        idle(2);

        // Index wrap: line 1024 aliases line 0.
        txn(0, 1'b1, 32'h4000, 128'hC0FFEE_0000_0000_0000_0000_1234, 1'b0);
        txn(0, 1'b0, 32'h0000, '0, 1'b0);

        // Aborted write: reset two cycles after acceptance.
        old80 = 128'h0123_4567_89AB_CDEF_0F0F_F0F0_1111_2222;
        txn(0, 1'b1, 32'h80, old80, 1'b0);
        drive(0, 1'b1, 1'b1, 32'h80, 128'hBAD0_BAD0_BAD0_BAD0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_rvalid5", DW'(rvalid5), 0);
        q5.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);
        txn(0, 1'b0, 32'h80, '0, 1'b0);
        check("abort_rdata5", rdata5, old80);

        // Random traffic on the LATENCY=5 instance.
        for (int i = 0; i < 16; i++) txn(0, 1'b1, AW'(i * 16), rand_line(), 1'b0);
        for (int i = 0; i < 40; i++) begin
            txn(0, 1'($urandom_range(0, 1)), rand_addr(), rand_line(),
                1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end

        // LATENCY=1 instance: reads on alternating cycles.
        for (int i = 0; i < 16; i++) txn(1, 1'b1, AW'(i * 16), rand_line(), 1'b0);
        for (int i = 0; i < 40; i++) begin
            txn(1, 1'($urandom_range(0, 3) == 0), rand_addr(), rand_line(),
                1'($urandom_range(0, 1)));
        end

        idle(10);
        check("q5_drained", DW'(q5.size()), 0);
        check("q1_drained", DW'(q1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
